// File: rtl/vga_pkg.sv
// vga_pkg: timing defaults, sync polarity and stage bundle
// shared by the VGA scan-out path.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF
                              + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF
                              + V_SYNC_DEF + V_BP_DEF;

  // Level driven on hsync/vsync while the pulse is asserted.
  localparam logic SYNC_ACT = 1'b0;

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic fs;
  } vga_flags_t;

  localparam vga_flags_t FLAGS_IDLE = '{
    act: 1'b0,
    hs:  ~SYNC_ACT,
    vs:  ~SYNC_ACT,
    fs:  1'b0
  };

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: h/v raster counters and stage-0 flags.
// Ports: clk, rst (sync, high) -> flags_o, h_act_o, v_act_o,
// line_end_o (last active pixel of an active line),
// frame_end_o (last cycle of the frame).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic       clk,
  input  logic       rst,
  output vga_flags_t flags_o,
  output logic       h_act_o,
  output logic       v_act_o,
  output logic       line_end_o,
  output logic       frame_end_o
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW    = cnt_w(H_TOT);
  localparam int VW    = cnt_w(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_ALAST = HW'(H_ACTIVE - 1);
  localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP
                                         + H_SYNC);

  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT   = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP
                                         + V_SYNC);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          h_wrap;
  logic          v_wrap;
  logic          in_hs;
  logic          in_vs;

  assign h_wrap = (h_cnt_q == H_LAST);
  assign v_wrap = (v_cnt_q == V_LAST);

  always_comb begin
    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign h_act_o = (h_cnt_q < H_ACT);
  assign v_act_o = (v_cnt_q < V_ACT);

  assign in_hs = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
  assign in_vs = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);

  assign line_end_o  = (h_cnt_q == H_ALAST) && v_act_o;
  assign frame_end_o = h_wrap && v_wrap;

  always_comb begin
    flags_o     = FLAGS_IDLE;
    flags_o.act = h_act_o && v_act_o;
    flags_o.hs  = in_hs ? SYNC_ACT : ~SYNC_ACT;
    flags_o.vs  = in_vs ? SYNC_ACT : ~SYNC_ACT;
    flags_o.fs  = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// vga_scanout: reads a scaled frame buffer over port B and
// drives VGA. Ports: clk, rst (sync, high), rd_addr/rd_data
// (1-cycle RAM read), hsync, vsync, de, rgb, frame_start.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 3,
  parameter int FB_XW    = 7,
  parameter int FB_H     = 96,
  parameter int SCALE    = 5,
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [DATA_W-1:0] rgb,
  output logic              frame_start
);

  localparam int FB_YW = ADDR_W - FB_XW;
  localparam int SW    = cnt_w(SCALE);

  localparam logic [SW-1:0]    S_LAST   = SW'(SCALE - 1);
  localparam logic [FB_YW-1:0] ROW_LAST = FB_YW'(FB_H - 1);

  vga_flags_t flags0;
  logic       h_act;
  logic       v_act;
  logic       line_end;
  logic       frame_end;

  vga_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .flags_o     (flags0),
    .h_act_o     (h_act),
    .v_act_o     (v_act),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  logic [SW-1:0]    xs_q, xs_d;
  logic [SW-1:0]    ys_q, ys_d;
  logic [FB_XW-1:0] col_q, col_d;
  logic [FB_YW-1:0] row_q, row_d;

  // Column side: col wraps naturally at 2^FB_XW, which lands
  // exactly on the last active pixel of the line.
  always_comb begin
    xs_d  = xs_q;
    col_d = col_q;
    if (!h_act || !v_act) begin
      xs_d  = '0;
      col_d = '0;
    end else if (xs_q == S_LAST) begin
      xs_d  = '0;
      col_d = col_q + FB_XW'(1);
    end else begin
      xs_d = xs_q + SW'(1);
    end
  end

  always_comb begin
    ys_d  = ys_q;
    row_d = row_q;
    if (!v_act || frame_end) begin
      ys_d  = '0;
      row_d = '0;
    end else if (line_end) begin
      if (ys_q == S_LAST) begin
        ys_d  = '0;
        row_d = (row_q == ROW_LAST) ? '0
              : row_q + FB_YW'(1);
      end else begin
        ys_d = ys_q + SW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xs_q  <= '0;
      ys_q  <= '0;
      col_q <= '0;
      row_q <= '0;
    end else begin
      xs_q  <= xs_d;
      ys_q  <= ys_d;
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Row-major with a power-of-two stride: plain concatenation.
  assign rd_addr = {row_q, col_q};

  // Stage 1 lines up with the RAM's registered read; stage 2
  // is the output register shared by rgb and the sync flags.
  vga_flags_t        st1_q, st1_d;
  vga_flags_t        st2_q, st2_d;
  logic [DATA_W-1:0] rgb_q, rgb_d;

  assign st1_d = flags0;
  assign st2_d = st1_q;
  assign rgb_d = rd_data & {DATA_W{st1_q.act}};

  always_ff @(posedge clk) begin
    if (rst) begin
      st1_q <= FLAGS_IDLE;
      st2_q <= FLAGS_IDLE;
      rgb_q <= '0;
    end else begin
      st1_q <= st1_d;
      st2_q <= st2_d;
      rgb_q <= rgb_d;
    end
  end

  assign hsync       = st2_q.hs;
  assign vsync       = st2_q.vs;
  assign de          = st2_q.act;
  assign frame_start = st2_q.fs;
  assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: default-size scan-out checked over its first
// lines, plus a reduced raster checked over whole frames.
module tb_vga_scanout;

  typedef struct {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int sc; int xw;
  } cfg_t;

  typedef struct {
    int de; int hs; int vs; int fs; int addr;
  } px_t;

  typedef struct {
    int m; int de; int hs; int vs; int fs; int rgb; int addr;
  } vec_t;

  localparam int NB = 8010;
  localparam int SFRAME = 24 * 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int ms     = 0;

  cfg_t cb;
  cfg_t cs;

  // Default-size instance
  logic        rst_b;
  logic [13:0] addr_b;
  logic [2:0]  rdata_b;
  logic        hs_b, vs_b, de_b, fs_b;
  logic [2:0]  rgb_b;
  logic [2:0]  mem_b [16384];

  always @(posedge clk) rdata_b <= mem_b[addr_b];

  vga_scanout u_big (
    .clk         (clk),
    .rst         (rst_b),
    .rd_addr     (addr_b),
    .rd_data     (rdata_b),
    .hsync       (hs_b),
    .vsync       (vs_b),
    .de          (de_b),
    .rgb         (rgb_b),
    .frame_start (fs_b)
  );

  // Reduced raster: 8x4 buffer, x2 scale, 24x14 total
  logic       rst_s;
  logic [4:0] addr_s;
  logic [2:0] rdata_s;
  logic       hs_s, vs_s, de_s, fs_s;
  logic [2:0] rgb_s;
  logic [2:0] mem_s [32];

  always @(posedge clk) rdata_s <= mem_s[addr_s];

  vga_scanout #(
    .ADDR_W (5), .DATA_W (3), .FB_XW (3), .FB_H (4),
    .SCALE (2),
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_sml (
    .clk         (clk),
    .rst         (rst_s),
    .rd_addr     (addr_s),
    .rd_data     (rdata_s),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .de          (de_s),
    .rgb         (rgb_s),
    .frame_start (fs_s)
  );

  function automatic int pack(input int de, input int hs,
                              input int vs, input int fs,
                              input int rgb);
    return de * 64 + hs * 32 + vs * 16 + fs * 8 + rgb;
  endfunction

  // Raster position p cycles after the top-left pixel.
  function automatic px_t model(input cfg_t c, input int p);
    px_t r;
    int ht, vt, h, v, hb, vb;
    ht = c.ha + c.hf + c.hsw + c.hb;
    vt = c.va + c.vf + c.vsw + c.vb;
    h  = p % ht;
    v  = (p / ht) % vt;
    hb = c.ha + c.hf;
    vb = c.va + c.vf;
    r.de   = (h < c.ha && v < c.va) ? 1 : 0;
    r.hs   = (h >= hb && h < hb + c.hsw) ? 0 : 1;
    r.vs   = (v >= vb && v < vb + c.vsw) ? 0 : 1;
    r.fs   = (h == 0 && v == 0) ? 1 : 0;
    r.addr = (v / c.sc) * (1 << c.xw) + h / c.sc;
    return r;
  endfunction

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h",
                  nm, act, exp);
  endtask

  function automatic int out_s();
    return pack(int'(de_s), int'(hs_s), int'(vs_s),
                int'(fs_s), int'(rgb_s));
  endfunction

  function automatic int out_b();
    return pack(int'(de_b), int'(hs_b), int'(vs_b),
                int'(fs_b), int'(rgb_b));
  endfunction

  // One clock on the reduced instance, checked against model.
  task automatic step_s(input bit r);
    px_t q;
    int  e;
    rst_s = r;
    @(posedge clk);
    @(negedge clk);
    if (r) begin
      ms = 0;
      chk("s_rst_out", out_s(), pack(0, 1, 1, 0, 0));
      chk("s_rst_addr", int'(addr_s), 0);
    end else begin
      ms++;
      if (ms < 2) begin
        e = pack(0, 1, 1, 0, 0);
      end else begin
        q = model(cs, ms - 2);
        e = pack(q.de, q.hs, q.vs, q.fs,
                 q.de != 0 ? int'(mem_s[q.addr]) : 0);
      end
      chk($sformatf("s_out@%0d", ms), out_s(), e);
      q = model(cs, ms);
      if (q.de != 0)
        chk($sformatf("s_addr@%0d", ms), int'(addr_s), q.addr);
    end
  endtask

  int   ob [NB];
  int   ab [NB];
  vec_t tv [19];

  initial begin
    px_t q;
    int  e, n_de, n_bad, n_vs, n_fs, n_hs;

    cb = '{640, 16, 96, 48, 480, 10, 2, 33, 5, 7};
    cs = '{16, 2, 3, 3, 8, 2, 2, 2, 2, 3};

    tv = '{
      '{1,    0, 1, 1, 0, 0, 0},
      '{2,    1, 1, 1, 1, 1, 0},
      '{3,    1, 1, 1, 0, 1, 0},
      '{5,    1, 1, 1, 0, 1, 1},
      '{6,    1, 1, 1, 0, 1, 1},
      '{7,    1, 1, 1, 0, 2, 1},
      '{10,   1, 1, 1, 0, 2, 2},
      '{12,   1, 1, 1, 0, 3, 2},
      '{641,  1, 1, 1, 0, 6, 0},
      '{642,  0, 1, 1, 0, 0, -1},
      '{657,  0, 1, 1, 0, 0, -1},
      '{658,  0, 0, 1, 0, 0, -1},
      '{753,  0, 0, 1, 0, 0, -1},
      '{754,  0, 1, 1, 0, 0, -1},
      '{801,  0, 1, 1, 0, 0, 0},
      '{802,  1, 1, 1, 0, 1, 0},
      '{4002, 1, 1, 1, 0, 5, 128},
      '{4007, 1, 1, 1, 0, 4, 129},
      '{4639, 1, 1, 1, 0, 7, 255}
    };

    rst_b = 1'b1;
    rst_s = 1'b1;
    for (int a = 0; a < 16384; a++)
      mem_b[a] = 3'($urandom_range(7));
    mem_b[0]   = 3'd1;
    mem_b[1]   = 3'd2;
    mem_b[2]   = 3'd3;
    mem_b[127] = 3'd6;
    mem_b[128] = 3'd5;
    mem_b[129] = 3'd4;
    mem_b[255] = 3'd7;
    for (int a = 0; a < 32; a++)
      mem_s[a] = 3'($urandom_range(7));

    // Default instance: reset, then record the first lines
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("b_rst_out", out_b(), pack(0, 1, 1, 0, 0));
      chk("b_rst_addr", int'(addr_b), 0);
    end
    rst_b = 1'b0;
    ob[0] = 0;
    ab[0] = 0;
    for (int m = 1; m < NB; m++) begin
      @(posedge clk);
      @(negedge clk);
      ob[m] = out_b();
      ab[m] = int'(addr_b);
    end

    foreach (tv[i]) begin
      chk($sformatf("vec%0d_out", i), ob[tv[i].m],
          pack(tv[i].de, tv[i].hs, tv[i].vs, tv[i].fs,
               tv[i].rgb));
      if (tv[i].addr >= 0)
        chk($sformatf("vec%0d_addr", i), ab[tv[i].m],
            tv[i].addr);
    end

    n_hs = 0;
    for (int m = 2; m < 802; m++)
      if ((ob[m] & 32) == 0) n_hs++;
    chk("b_hsync_low_cycles", n_hs, 96);

    for (int m = 1; m < NB; m++) begin
      if (m < 2) begin
        e = pack(0, 1, 1, 0, 0);
      end else begin
        q = model(cb, m - 2);
        e = pack(q.de, q.hs, q.vs, q.fs,
                 q.de != 0 ? int'(mem_b[q.addr]) : 0);
      end
      chk($sformatf("b_out@%0d", m), ob[m], e);
      q = model(cb, m);
      if (q.de != 0)
        chk($sformatf("b_addr@%0d", m), ab[m], q.addr);
    end

    // Reduced raster: three whole frames from reset
    repeat (3) step_s(1'b1);
    for (int k = 0; k < 3 * SFRAME; k++) begin
      step_s(1'b0);
      if (ms == 7 * 24)
        chk("s_last_row_start", int'(addr_s), 24);
      if (ms == 7 * 24 + 15)
        chk("s_last_row_end", int'(addr_s), 31);
    end

    // Blanking with a buffer full of 7
    for (int a = 0; a < 32; a++) mem_s[a] = 3'd7;
    step_s(1'b1);
    n_de  = 0;
    n_bad = 0;
    n_vs  = 0;
    n_fs  = 0;
    for (int k = 0; k < 2 * SFRAME; k++) begin
      step_s(1'b0);
      if (ms >= 2 && ms < 2 + SFRAME) begin
        if (de_s) n_de++;
        if (!vs_s) n_vs++;
      end
      if (!de_s && rgb_s != 3'd0) n_bad++;
      if (fs_s) n_fs++;
    end
    chk("s_de_per_frame", n_de, 16 * 8);
    chk("s_rgb_in_blank", n_bad, 0);
    chk("s_vsync_low_cycles", n_vs, 2 * 24);
    chk("s_fs_pulses", n_fs, 2);

    // Mid-frame reset at line 3, pixel 7
    for (int a = 0; a < 32; a++)
      mem_s[a] = 3'($urandom_range(7));
    step_s(1'b1);
    repeat (3 * 24 + 7) step_s(1'b0);
    step_s(1'b1);
    step_s(1'b0);
    chk("s_midrst_quiet", out_s(), pack(0, 1, 1, 0, 0));
    step_s(1'b0);
    chk("s_midrst_fs", int'(fs_s), 1);
    chk("s_midrst_de", int'(de_s), 1);

    // Random single-cycle resets
    for (int k = 0; k < 1500; k++)
      step_s($urandom_range(149) == 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_scanout.md
# vga_scanout

Display scan-out stage that reads pixels from port B of the 128×96×3-bit true dual-port frame buffer and drives a 640×480@60 VGA output. Each framebuffer pixel is replicated 5× horizontally and 5× vertically. Port A stays free for the CPU/writer side. The block generates the read address, absorbs the RAM's 1-cycle registered read latency, and keeps sync/blanking aligned with pixel data.

## Interface
Parameters:
- ADDR_W, 14, framebuffer address width; must equal FB_XW + FB_YW.
- DATA_W, 3, pixel width (1 bit each R, G, B).
- FB_XW, 7, framebuffer column index width (128 columns).
- FB_H, 96, framebuffer rows.
- SCALE, 5, pixel replication factor on both axes.
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in clocks; H_TOTAL = 800.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines; V_TOTAL = 525.
- Constraints: H_ACTIVE = 2^FB_XW × SCALE and V_ACTIVE = FB_H × SCALE.

Ports:
- clk  in  1  pixel clock (25 MHz nominal); one pixel per cycle.
- rst  in  1  reset; synchronous, active-high.
- rd_addr  out  ADDR_W  framebuffer read address; connects to addr_b, with we_b tied 0.
- rd_data  in  DATA_W  framebuffer q_b; valid 1 cycle after rd_addr.
- hsync  out  1  horizontal sync, active-low.
- vsync  out  1  vertical sync, active-low.
- de  out  1  data enable; high during visible pixels.
- rgb  out  DATA_W  pixel output; forced 0 when de is low.
- frame_start  out  1  1-cycle pulse, coincident with the first visible pixel of each frame at the outputs.

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1.
  - v_cnt runs 0..V_TOTAL-1 and increments when h_cnt wraps.
  - v_cnt wraps to 0 after V_TOTAL-1.
- Replication counters:
  - xs runs 0..SCALE-1 and advances on every active-h cycle.
  - col runs 0..127 and increments when xs wraps.
  - xs and col clear to 0 whenever h_cnt ≥ H_ACTIVE.
  - ys runs 0..SCALE-1 and advances at each end of an active line.
  - row runs 0..FB_H-1 and increments when ys wraps.
  - ys and row clear to 0 when v_cnt ≥ V_ACTIVE.
- rd_addr = {row, col}, combinational from registered counters (row×128 + col; no multiplier).
  - During blanking it holds the value {0,0} or the current row with col = 0; its content is ignored.
- Stage-0 flags, derived from counters:
  - act0 = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs0 = low while h_cnt ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - vs0 = low while v_cnt ∈ [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
  - fs0 = (h_cnt == 0 && v_cnt == 0).
- Flags pass through a 2-stage delay line. rgb is registered as rd_data & {DATA_W{act1}}, where act1 is the 1-stage-delayed act0.
- Reset values:
  - All counters 0.
  - hsync = 1, vsync = 1, de = 0, rgb = 0, frame_start = 0, rd_addr = 0.
  - Delay-line stages cleared to their inactive values.
- After reset release, scanning starts at h_cnt = 0, v_cnt = 0, i.e. the top-left visible pixel.

## Timing
- Latency from counter state to outputs is 2 cycles for hsync, vsync, de, rgb and frame_start; all five are mutually aligned.
- The pixel at framebuffer (r, c) appears on rgb for 5 consecutive cycles on each of 5 consecutive lines.
- Line boundary: when col = 127 and xs = 4, the next cycle enters blanking; col and xs return to 0 for the next line.
- Frame boundary: when row = 95 and ys = 4 at the end of active line 479, row and ys clear. rd_addr for line 0 of the next frame starts at 0.
- rst asserted mid-frame:
  - Counters and outputs reach reset values on the next clk edge.
  - In-flight pipeline data is discarded.
  - Sync pulses may be truncated; downstream tolerates this.
- hsync and vsync are independent. vsync changes only on the cycle where the delayed h_cnt = 0.
- No handshakes: rd_data is sampled unconditionally every cycle.

## Structure
- Package vga_pkg holds the timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL) and the sync-polarity constant.
- Sub-module vga_timing_gen holds h_cnt and v_cnt and produces act0, hs0, vs0, fs0 plus line_end and frame_end strobes.
- vga_scanout holds the replication counters, address formation, delay line and output registers.

## Test plan
- Reset: hold rst for 3 cycles, then release.
  - During rst: hsync = 1, vsync = 1, de = 0, rgb = 0, rd_addr = 0.
  - After release: first de = 1 and frame_start = 1 occur 2 cycles after release.
- Replication: load RAM[0..2] = 1, 2, 3.
  - rgb on line 0 is 1 for 5 cycles, then 2 for 5 cycles, then 3.
  - rd_addr steps 0 → 1 → 2 every 5 cycles.
- Row stepping: rd_addr during active lines 0–4 starts at 0 on each line; lines 5–9 start at 128; line 479 starts at 95×128 = 12160 and ends at 12287.
- Sync timing:
  - hsync is low for exactly 96 cycles, from output cycle 656 through 751 of each line.
  - vsync is low on lines 490–491.
  - Line period is 800 cycles; frame period is 420000 cycles.
- Blanking: RAM filled with 7.
  - rgb = 0 whenever de = 0, including h = 640..799 and v = 480..524.
  - de is high for exactly 640 × 480 cycles per frame.
- Mid-frame reset: assert rst at v = 200, h = 300 for 1 cycle.
  - Next cycle, outputs return to reset values.
  - frame_start pulses 2 cycles after release, and rd_addr restarts at 0.
